// File: rtl/sccb_config_sequencer_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
package sccb_config_sequencer_pkg;

  // Sequencer FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_WRITE,
    ST_SETTLE,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // Bit-engine phase encoding
  typedef enum logic [1:0] {
    EN_IDLE,
    EN_START,
    EN_BITS,
    EN_STOP
  } eng_phase_t;

  // Register whose bit 7 triggers a sensor soft reset
  localparam logic [7:0] SOFT_RESET_REG = 8'h12;

  // Three bytes plus three ack slots in one 3-phase write
  localparam int SCCB_WRITE_BITS = 27;

  // Ack slots follow each byte: bit positions 8, 17 and 26
  function automatic logic is_ack_bit(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_write_engine.sv
// SCCB 3-phase write bit engine: START, 27 bits MSB first, STOP.
// Each bit is one SCL period: SCL low for the first half, high for the
// second. SDA moves at mid-low, ack is sampled at mid-high. SDA is only
// ever pulled low or released; sda_low drives the open-drain pad.
module sccb_write_engine
  import sccb_config_sequencer_pkg::*;
#(
  parameter int SCL_PER = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] cmd,      // {addr, reg, data}
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_low,
  output logic        done,
  output logic        nack
);

  localparam int CW       = $clog2(SCL_PER + 1);
  localparam int LOW_LEN  = SCL_PER - SCL_PER / 2;
  localparam int HIGH_LEN = SCL_PER / 2;

  localparam logic [CW-1:0] T_FALL = '0;
  localparam logic [CW-1:0] T_SDA  = CW'(LOW_LEN / 2);
  localparam logic [CW-1:0] T_RISE = CW'(LOW_LEN);
  localparam logic [CW-1:0] T_SMP  = CW'(LOW_LEN + HIGH_LEN / 2);
  localparam logic [CW-1:0] T_END  = CW'(SCL_PER - 1);
  localparam logic [CW-1:0] T_HOLD = CW'(LOW_LEN - 1);
  localparam logic [4:0]    LAST_BIT = 5'(SCCB_WRITE_BITS - 1);

  eng_phase_t                 phase;
  logic [CW-1:0]              tick;
  logic [4:0]                 bit_idx;
  logic [SCCB_WRITE_BITS-1:0] shreg;

  // Frame sequencer: START hold, per-bit SCL/SDA timing, STOP, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= EN_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      scl     <= 1'b1;
      sda_low <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        EN_IDLE: begin
          if (start) begin
            // Ack slots load as 1 so SDA is released for the slave
            shreg   <= {cmd[23:16], 1'b1, cmd[15:8], 1'b1, cmd[7:0], 1'b1};
            nack    <= 1'b0;
            sda_low <= 1'b1;          // START: SDA falls while SCL high
            tick    <= '0;
            phase   <= EN_START;
          end
        end
        EN_START: begin
          if (tick == T_HOLD) begin
            tick    <= '0;
            bit_idx <= '0;
            phase   <= EN_BITS;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        EN_BITS: begin
          if (tick == T_FALL) scl <= 1'b0;
          if (tick == T_SDA)  sda_low <= ~shreg[SCCB_WRITE_BITS-1];
          if (tick == T_RISE) scl <= 1'b1;
          if (tick == T_SMP && is_ack_bit(bit_idx) && sda_in) nack <= 1'b1;
          if (tick == T_END) begin
            tick  <= '0;
            shreg <= {shreg[SCCB_WRITE_BITS-2:0], 1'b0};
            if (bit_idx == LAST_BIT) phase <= EN_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        EN_STOP: begin
          if (tick == T_FALL) scl <= 1'b0;
          if (tick == T_SDA)  sda_low <= 1'b1;
          if (tick == T_RISE) scl <= 1'b1;
          if (tick == T_SMP)  sda_low <= 1'b0;   // STOP: SDA rises while SCL high
          if (tick == T_END) begin
            tick  <= '0;
            done  <= 1'b1;
            phase <= EN_IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: phase <= EN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks a register LUT and writes each entry to an SCCB sensor, with
// power-up delay, per-entry NACK retries and a settle delay after a
// soft-reset write. The bit-level protocol lives in sccb_write_engine.
module sccb_config_sequencer
  import sccb_config_sequencer_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         SCCB_FREQ  = 100_000,
  parameter logic [7:0] SLAVE_ADDR = 8'h42,
  parameter int         LUT_FIRST  = 2,
  parameter int         LUT_LAST   = 166,
  parameter int         PWRUP_CYC  = 1_000_000,
  parameter int         SETTLE_CYC = 50_000,
  parameter int         RETRY_MAX  = 3
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  output logic [7:0]  oLUT_INDEX,
  input  logic [15:0] iLUT_DATA,
  output logic        oSCCB_SCLK,
  inout  wire         ioSCCB_SDAT,
  output logic        oBUSY,
  output logic        oCONFIG_DONE,
  output logic        oCONFIG_ERR
);

  localparam logic [7:0]  IDX_FIRST   = 8'(LUT_FIRST);
  localparam logic [7:0]  IDX_LAST    = 8'(LUT_LAST);
  localparam logic [31:0] PWRUP_LAST  = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [7:0]  RETRY_LAST  = 8'(RETRY_MAX - 1);

  seq_state_t  state;
  logic [31:0] cnt;
  logic [7:0]  retry;
  logic [23:0] cmd;
  logic        eng_start;
  logic        eng_done;
  logic        eng_nack;
  logic        sda_low;

  // Open-drain pad: pull low or release
  assign ioSCCB_SDAT = sda_low ? 1'b0 : 1'bz;

  sccb_write_engine #(
    .SCL_PER (CLK_FREQ / SCCB_FREQ)
  ) u_eng (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .start   (eng_start),
    .cmd     (cmd),
    .sda_in  (ioSCCB_SDAT),
    .scl     (oSCCB_SCLK),
    .sda_low (sda_low),
    .done    (eng_done),
    .nack    (eng_nack)
  );

  // Sequencer FSM: LUT walk, retries, power-up and settle delays
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= ST_IDLE;
      oLUT_INDEX   <= IDX_FIRST;
      oBUSY        <= 1'b0;
      oCONFIG_DONE <= 1'b0;
      oCONFIG_ERR  <= 1'b0;
      cnt          <= '0;
      retry        <= '0;
      cmd          <= '0;
      eng_start    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          oBUSY <= 1'b1;
          cnt   <= '0;
          if (iSTART) begin
            oLUT_INDEX <= IDX_FIRST;
            retry      <= '0;
            state      <= ST_FETCH;
          end else begin
            state <= ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt        <= '0;
            oLUT_INDEX <= IDX_FIRST;
            retry      <= '0;
            state      <= ST_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          // Index has been stable for this cycle, so LUT data is valid
          cmd       <= {SLAVE_ADDR, iLUT_DATA};
          eng_start <= 1'b1;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (eng_done) begin
            if (eng_nack) begin
              if (retry == RETRY_LAST) begin
                oBUSY       <= 1'b0;
                oCONFIG_ERR <= 1'b1;
                state       <= ST_ERROR;
              end else begin
                retry <= retry + 1'b1;
                state <= ST_FETCH;
              end
            end else if (cmd[15:8] == SOFT_RESET_REG && cmd[7]) begin
              cnt   <= '0;
              state <= ST_SETTLE;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (oLUT_INDEX == IDX_LAST) begin
            oBUSY        <= 1'b0;
            oCONFIG_DONE <= 1'b1;
            state        <= ST_DONE;
          end else begin
            oLUT_INDEX <= oLUT_INDEX + 1'b1;
            retry      <= '0;
            state      <= ST_FETCH;
          end
        end
        ST_DONE, ST_ERROR: begin
          // Restart skips the power-up wait
          if (iSTART) begin
            oBUSY        <= 1'b1;
            oCONFIG_DONE <= 1'b0;
            oCONFIG_ERR  <= 1'b0;
            oLUT_INDEX   <= IDX_FIRST;
            retry        <= '0;
            state        <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: a slave model decodes each SCCB write from the bus and
// the main sequence compares it against a queue of expected writes.
module tb_sccb_config_sequencer;

  localparam int PWRUP  = 100;
  localparam int SETTLE = 300;
  localparam int PER    = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  idx;
  logic [15:0] lut_data;
  logic        scl;
  logic        busy;
  logic        done;
  logic        err;
  wire         sda;
  logic        slv_drv = 1'b0;

  logic [15:0] lut [0:7];

  assign sda = slv_drv ? 1'b0 : 1'bz;
  pullup (sda);
  assign lut_data = (idx < 8'd8) ? lut[idx[2:0]] : 16'hffff;

  always #5 clk = ~clk;

  sccb_config_sequencer #(
    .CLK_FREQ   (4_000_000),
    .SCCB_FREQ  (100_000),
    .SLAVE_ADDR (8'h42),
    .LUT_FIRST  (2),
    .LUT_LAST   (4),
    .PWRUP_CYC  (PWRUP),
    .SETTLE_CYC (SETTLE),
    .RETRY_MAX  (3)
  ) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iSTART       (start),
    .oLUT_INDEX   (idx),
    .iLUT_DATA    (lut_data),
    .oSCCB_SCLK   (scl),
    .ioSCCB_SDAT  (sda),
    .oBUSY        (busy),
    .oCONFIG_DONE (done),
    .oCONFIG_ERR  (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model state
  logic [7:0]  nack_idx = 8'd3;
  int          nack_budget = 0;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;
  int          bitn = 0;
  logic [27:0] shv = '0;
  logic        s_nack = 1'b0;
  int          att = 0;
  logic [7:0]  last_idx = 8'hff;
  int          rise0 = 0;
  int          scl_per = 0;
  logic [23:0] got_w [$];
  int          start_t [$];
  int          stop_t [$];

  // Slave: decode START/bits/STOP, drive acks, NACK selected attempts.
  // The STOP's SCL rise is counted as a 28th rise, hence the offsets.
  always @(negedge clk) begin
    if (!rst_n) slv_drv = 1'b0;
    if (p_scl && scl && p_sda && !sda) begin
      bitn = 0;
      if (idx != last_idx) att = 0;
      last_idx = idx;
      s_nack = (idx == nack_idx) && (att < nack_budget);
      att++;
      start_t.push_back(cyc);
    end else if (p_scl && scl && !p_sda && sda) begin
      if (bitn == 28) begin
        got_w.push_back({shv[27:20], shv[18:11], shv[9:2]});
        stop_t.push_back(cyc);
      end
    end else if (!p_scl && scl) begin
      if (bitn == 0) rise0 = cyc;
      if (bitn == 1) scl_per = cyc - rise0;
      shv = {shv[26:0], sda};
      bitn++;
    end else if (p_scl && !scl) begin
      slv_drv = !s_nack && (bitn == 8 || bitn == 17 || bitn == 26);
    end
    p_scl = scl;
    p_sda = sda;
  end

  int          compared = 0;
  int          mismatched = 0;
  logic [23:0] exp_q [$];
  int          rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_w(input logic [15:0] e);
    exp_q.push_back({8'h42, e});
  endtask

  task automatic check_w(input string tag);
    int n = 0;
    logic [23:0] e;
    while (got_w.size() <= rd && n < 4000) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h0;
    if (got_w.size() <= rd) chk({tag, "_timeout"}, 32'(got_w.size()), 32'(rd + 1));
    else begin
      chk(tag, {8'h0, got_w[rd]}, {8'h0, e});
      rd++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    int t0, bs, bp, g1, g2, n;
    rst_n = 1'b0;
    start = 1'b0;
    lut[0] = 16'h7fa2; lut[1] = 16'h7fa3; lut[2] = 16'h1200; lut[3] = 16'h4080;
    lut[4] = 16'h3a0d; lut[5] = 16'hffff; lut[6] = 16'hffff; lut[7] = 16'hffff;
    repeat (3) @(negedge clk);
    chk("rst_scl",  32'(scl),  1);
    chk("rst_sda",  32'(sda),  1);
    chk("rst_idx",  32'(idx),  2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(err),  0);

    // Pass 1: power-up, three writes, iSTART mid-write ignored
    rst_n = 1'b1;
    t0 = cyc;
    expect_w(16'h1200); expect_w(16'h4080); expect_w(16'h3a0d);
    n = 0;
    while (start_t.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    chk("p1_first_start", 32'(start_t.size() > 0), 1);
    chk("p1_pwrup_wait", 32'((start_t.size() > 0) && (start_t[0] - t0 >= PWRUP)), 1);
    repeat (200) @(negedge clk);
    chk("p1_busy_mid_write", 32'(busy), 1);
    pulse_start();
    check_w("p1_w0");
    check_w("p1_w1");
    check_w("p1_w2");
    chk("scl_period", 32'(scl_per), PER);
    wait_done("p1_done");
    chk("p1_idx_last", 32'(idx), 4);
    chk("p1_busy_off", 32'(busy), 0);

    // Pass 2: restart without power-up, soft-reset entry settles
    lut[3] = 16'h1280;
    bs = start_t.size();
    bp = stop_t.size();
    t0 = cyc;
    pulse_start();
    chk("p2_done_cleared", 32'(done), 0);
    expect_w(16'h1200); expect_w(16'h1280); expect_w(16'h3a0d);
    check_w("p2_w0");
    check_w("p2_w1");
    check_w("p2_w2");
    if (start_t.size() >= bs + 3 && stop_t.size() >= bp + 2) begin
      g1 = start_t[bs + 1] - stop_t[bp];
      g2 = start_t[bs + 2] - stop_t[bp + 1];
      chk("p2_settle_extra", 32'(g2 - g1), SETTLE);
      chk("p2_no_pwrup", 32'(start_t[bs] - t0 < PWRUP), 1);
    end else begin
      chk("p2_start_count", 32'(start_t.size()), 32'(bs + 3));
    end
    wait_done("p2_done");

    // Pass 3: index 3 NACKed twice, third attempt acked
    lut[3] = 16'h4080;
    nack_budget = 2;
    pulse_start();
    expect_w(16'h1200); expect_w(16'h4080); expect_w(16'h4080);
    expect_w(16'h4080); expect_w(16'h3a0d);
    check_w("p3_w0");
    check_w("p3_w1_nack");
    check_w("p3_w2_nack");
    check_w("p3_w3_ack");
    check_w("p3_w4");
    wait_done("p3_done");
    chk("p3_err_low", 32'(err), 0);

    // Pass 4: index 3 always NACKed -> error after three attempts
    nack_budget = 255;
    bs = start_t.size();
    pulse_start();
    expect_w(16'h1200); expect_w(16'h4080); expect_w(16'h4080); expect_w(16'h4080);
    check_w("p4_w0");
    check_w("p4_w1");
    check_w("p4_w2");
    check_w("p4_w3");
    n = 0;
    while (!err && n < 200) begin @(negedge clk); n++; end
    chk("p4_err",  32'(err),  1);
    chk("p4_busy", 32'(busy), 0);
    chk("p4_idx",  32'(idx),  3);
    chk("p4_done", 32'(done), 0);
    repeat (3000) @(negedge clk);
    chk("p4_no_more_start", 32'(start_t.size()), 32'(bs + 4));

    // Pass 5: reset mid data byte, then full rerun with power-up
    nack_budget = 0;
    bs = start_t.size();
    pulse_start();
    n = 0;
    while (!(start_t.size() > bs && bitn >= 19 && bitn <= 25 && sda === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("p5_mid_byte_reached", 32'(start_t.size() > bs && sda === 1'b0), 1);
    rst_n = 1'b0;
    #1;
    chk("p5_rst_scl",  32'(scl),  1);
    chk("p5_rst_sda",  32'(sda),  1);
    chk("p5_rst_busy", 32'(busy), 0);
    chk("p5_rst_idx",  32'(idx),  2);
    chk("p5_rst_done", 32'(done), 0);
    chk("p5_rst_err",  32'(err),  0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    bs = start_t.size();
    expect_w(16'h1200); expect_w(16'h4080); expect_w(16'h3a0d);
    check_w("p5_w0");
    check_w("p5_w1");
    check_w("p5_w2");
    chk("p5_pwrup_rerun", 32'((start_t.size() > bs) && (start_t[bs] - t0 >= PWRUP)), 1);
    wait_done("p5_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
